seq_detect_ctrl: RTL and testbench

Run-time configurable serial sequence detector with its own control state machine. Software or a host FSM loads a pattern (1 to MAX_LEN bits), a length, an overlap/non-overlap mode and a target match count, then arms the block. The block scans a qualified serial bit stream, emits registered glitch-free match pulses, counts matches and signals completion. It sits between the serial input front-end and the status/interrupt logic.

---
 rtl/seq_detect_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-time configurable serial sequence detector.
// A host loads pattern/length/overlap/target while the block is idle,
// arms it with start, and the block scans the qualified serial stream,
// emitting registered match pulses, a saturating match count and a
// one-cycle done pulse when the target count is reached.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,   // maximum pattern length in bits (2..16)
  parameter int LEN_W   = 5,   // width of cfg_len, must hold MAX_LEN
  parameter int CNT_W   = 8    // width of match counter and cfg_target
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               x,
  input  logic               x_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LEN_W-1:0]   LEN_MAX_V   = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(3'b110);
  localparam logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(3);
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

  // Control state and configuration registers
  logic [1:0]         r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target;

  // Datapath registers
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [CNT_W-1:0]   r_count;
  logic               r_match;
  logic               r_done;

  // Combinational helpers
  logic               w_cfg_ready;
  logic               w_cfg_load;
  logic [LEN_W-1:0]   w_len_in;
  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic               w_sample;
  logic               w_hit;
  logic [CNT_W-1:0]   w_count_inc;
  logic               w_reach;

  assign w_cfg_ready = (r_state != S_RUN);
  assign w_cfg_load  = cfg_valid && w_cfg_ready;

  // Clamp the requested length into 1..MAX_LEN before it is stored
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // signal unassigned; otherwise synthesis infers a latch.
    w_len_in = cfg_len;
    if (cfg_len == '0) begin
      w_len_in = LEN_W'(1);
    end else if (cfg_len > LEN_MAX_V) begin
      w_len_in = LEN_MAX_V;
    end
  end

  // Mask selecting the low r_len bits of history and pattern
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  // A sample only counts in RUN when neither stop nor start overrides it
  assign w_sample    = (r_state == S_RUN) && x_valid && !stop && !start;
  assign w_hist_next = {r_hist[MAX_LEN-2:0], x};
  assign w_fill_next = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);
  assign w_hit       = w_sample && (w_fill_next == r_len) &&
                       (((w_hist_next ^ r_pattern) & w_mask) == '0);
  assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);
  assign w_reach     = (r_target != '0) && (w_count_inc == r_target);

  // Configuration latch: accepted only while not running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= DEF_LEN;
      r_overlap <= 1'b0;
      r_target  <= '0;
    end else if (w_cfg_load) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      r_pattern <= cfg_pattern;
      r_len     <= w_len_in;
      r_overlap <= cfg_overlap;
      r_target  <= cfg_target;
    end
  end

  // Control FSM with history, fill, counter and pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
      r_match <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_match <= 1'b0;
      r_done  <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
      end else if (start) begin
        r_state <= S_RUN;
        r_hist  <= '0;
        r_fill  <= '0;
        r_count <= '0;
      end else if (w_sample) begin
        if (w_hit) begin
          r_match <= 1'b1;
          r_count <= w_count_inc;
          if (r_overlap) begin
            r_hist <= w_hist_next;
            r_fill <= w_fill_next;
          end else begin
            r_hist <= '0;
            r_fill <= '0;
          end
          if (w_reach) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end else begin
          r_hist <= w_hist_next;
          r_fill <= w_fill_next;
        end
      end
    end
  end

  assign cfg_ready   = w_cfg_ready;
  assign busy        = (r_state == S_RUN);
  assign match       = r_match;
  assign done        = r_done;
  assign match_count = r_count;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed testbench for seq_detect_ctrl. Each driven cycle pushes the
// expected {match, done} pair into a scoreboard queue; the pair is popped
// and compared after the following clock edge.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 5;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               stop;
  logic               x;
  logic               x_valid;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .stop        (stop),
    .x           (x),
    .x_valid     (x_valid),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle (to the next falling edge), release one-shot
  // controls and compare the oldest scoreboard entry with match/done.
  task automatic tick(input string tag);
    logic [1:0] e;
    @(negedge clk);
    x_valid   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_match"}, {31'd0, match}, {31'd0, e[1]});
      check({tag, "_done"},  {31'd0, done},  {31'd0, e[0]});
    end
  endtask

  task automatic drive_bit(input string tag, input logic b, input logic em, input logic ed);
    x = b;
    x_valid = 1'b1;
    exp_q.push_back({em, ed});
    tick(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(2'b00);
      tick(tag);
    end
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    exp_q.push_back(2'b00);
    tick(tag);
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    exp_q.push_back(2'b00);
    tick(tag);
  endtask

  // Present a config word; it is applied on the next tick.
  task automatic set_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                         input logic ov, input logic [CNT_W-1:0] t);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cfg_target  = t;
    cfg_valid   = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_match", {31'd0, match}, 32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_cnt",   {24'd0, match_count}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);

    // 1: default 110, non-overlap, target 0
    do_start("t1_start");
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_ready", {31'd0, cfg_ready}, 32'd0);
    drive_bit("t1_b1", 1'b1, 1'b0, 1'b0);
    drive_bit("t1_b2", 1'b1, 1'b0, 1'b0);
    drive_bit("t1_b3", 1'b0, 1'b1, 1'b0);
    drive_bit("t1_b4", 1'b1, 1'b0, 1'b0);
    drive_bit("t1_b5", 1'b1, 1'b0, 1'b0);
    drive_bit("t1_b6", 1'b0, 1'b1, 1'b0);
    check("t1_cnt", {24'd0, match_count}, 32'd2);

    // 2a: pattern 101 overlap, config and start in the same cycle
    do_stop("t2_stop");
    check("t2_cnt_hold", {24'd0, match_count}, 32'd2);
    set_cfg(8'b101, 5'd3, 1'b1, 8'd0);
    do_start("t2a_start");
    drive_bit("t2a_b1", 1'b1, 1'b0, 1'b0);
    drive_bit("t2a_b2", 1'b0, 1'b0, 1'b0);
    drive_bit("t2a_b3", 1'b1, 1'b1, 1'b0);
    drive_bit("t2a_b4", 1'b0, 1'b0, 1'b0);
    drive_bit("t2a_b5", 1'b1, 1'b1, 1'b0);
    check("t2a_cnt", {24'd0, match_count}, 32'd2);

    // 2b: same stream non-overlap
    do_stop("t2b_stop");
    set_cfg(8'b101, 5'd3, 1'b0, 8'd0);
    do_start("t2b_start");
    drive_bit("t2b_b1", 1'b1, 1'b0, 1'b0);
    drive_bit("t2b_b2", 1'b0, 1'b0, 1'b0);
    drive_bit("t2b_b3", 1'b1, 1'b1, 1'b0);
    drive_bit("t2b_b4", 1'b0, 1'b0, 1'b0);
    drive_bit("t2b_b5", 1'b1, 1'b0, 1'b0);
    check("t2b_cnt", {24'd0, match_count}, 32'd1);

    // 3: target 2, done with the 2nd match, later samples ignored
    do_stop("t3_stop");
    set_cfg(8'b110, 5'd3, 1'b0, 8'd2);
    do_start("t3_start");
    drive_bit("t3_b1", 1'b1, 1'b0, 1'b0);
    drive_bit("t3_b2", 1'b1, 1'b0, 1'b0);
    drive_bit("t3_b3", 1'b0, 1'b1, 1'b0);
    drive_bit("t3_b4", 1'b1, 1'b0, 1'b0);
    drive_bit("t3_b5", 1'b1, 1'b0, 1'b0);
    drive_bit("t3_b6", 1'b0, 1'b1, 1'b1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_ready", {31'd0, cfg_ready}, 32'd1);
    drive_bit("t3_b7", 1'b1, 1'b0, 1'b0);
    drive_bit("t3_b8", 1'b1, 1'b0, 1'b0);
    drive_bit("t3_b9", 1'b0, 1'b0, 1'b0);
    check("t3_cnt", {24'd0, match_count}, 32'd2);

    // 4: stop (with a coincident sample) clears history; gaps are transparent
    do_start("t4_start");
    check("t4_cnt_clr", {24'd0, match_count}, 32'd0);
    drive_bit("t4_b1", 1'b1, 1'b0, 1'b0);
    drive_bit("t4_b2", 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    drive_bit("t4_stop_x", 1'b0, 1'b0, 1'b0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    do_start("t4_restart");
    drive_bit("t4_b3", 1'b0, 1'b0, 1'b0);
    do_start("t4_restart2");
    drive_bit("t4_g1", 1'b1, 1'b0, 1'b0);
    idle("t4_gap1", 3);
    drive_bit("t4_g2", 1'b1, 1'b0, 1'b0);
    idle("t4_gap2", 3);
    drive_bit("t4_g3", 1'b0, 1'b1, 1'b0);
    check("t4_cnt", {24'd0, match_count}, 32'd1);

    // 5a: config write during RUN is ignored, old pattern still active
    set_cfg(8'b101, 5'd3, 1'b1, 8'd0);
    #1;
    check("t5_ready_run", {31'd0, cfg_ready}, 32'd0);
    idle("t5_cfg_run", 1);
    drive_bit("t5_b1", 1'b1, 1'b0, 1'b0);
    drive_bit("t5_b2", 1'b0, 1'b0, 1'b0);
    drive_bit("t5_b3", 1'b1, 1'b0, 1'b0);
    drive_bit("t5_b4", 1'b1, 1'b0, 1'b0);
    drive_bit("t5_b5", 1'b0, 1'b1, 1'b1);
    check("t5_cnt", {24'd0, match_count}, 32'd2);

    // 5b: cfg_len 0 behaves as length 1
    set_cfg(8'b0000_0001, 5'd0, 1'b0, 8'd0);
    do_start("t5b_start");
    drive_bit("t5b_b1", 1'b1, 1'b1, 1'b0);
    drive_bit("t5b_b2", 1'b1, 1'b1, 1'b0);
    drive_bit("t5b_b3", 1'b0, 1'b0, 1'b0);
    check("t5b_cnt", {24'd0, match_count}, 32'd2);

    // 5c: cfg_len 20 behaves as length 8
    do_stop("t5c_stop");
    set_cfg(8'b1010_0101, 5'd20, 1'b0, 8'd0);
    do_start("t5c_start");
    drive_bit("t5c_b1", 1'b1, 1'b0, 1'b0);
    drive_bit("t5c_b2", 1'b0, 1'b0, 1'b0);
    drive_bit("t5c_b3", 1'b1, 1'b0, 1'b0);
    drive_bit("t5c_b4", 1'b0, 1'b0, 1'b0);
    drive_bit("t5c_b5", 1'b0, 1'b0, 1'b0);
    drive_bit("t5c_b6", 1'b1, 1'b0, 1'b0);
    drive_bit("t5c_b7", 1'b0, 1'b0, 1'b0);
    drive_bit("t5c_b8", 1'b1, 1'b1, 1'b0);
    check("t5c_cnt", {24'd0, match_count}, 32'd1);

    // 6: async reset between edges while a match pulse is high
    check("t6_pre_match", {31'd0, match}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_match", {31'd0, match}, 32'd0);
    check("t6_cnt",   {24'd0, match_count}, 32'd0);
    check("t6_busy",  {31'd0, busy}, 32'd0);
    check("t6_done",  {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_start("t6_start");
    drive_bit("t6_b1", 1'b1, 1'b0, 1'b0);
    drive_bit("t6_b2", 1'b1, 1'b0, 1'b0);
    drive_bit("t6_b3", 1'b0, 1'b1, 1'b0);
    check("t6_cnt_after", {24'd0, match_count}, 32'd1);
    check("t6_sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on run time in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
